sat_search_ctrl: RTL and testbench
==================================

// Module: sat_search_ctrl
// PURPOSE
//   Upstream sequencer for the literal-select muxes. Stores a 3-literal CNF clause list loaded serially, then brute-forces
//   assignments x = 0..2^NUM_VARS-1. Drives one clause's literals per cycle to three external mux instances and consumes
//   their per-literal truth bits. Stops on the first satisfying assignment (SAT) or after exhausting all assignments (UNSAT).
// PARAMETERS
//   NUM_VARS          6   variables; x width; literal magnitudes 1..NUM_VARS
//   LOG2_NUM_CLAUSES  5   clause store depth = 2**LOG2_NUM_CLAUSES (32)
// PORTS
//   clk        in   1                   clock, all state updates on rising edge
//   rst_n      in   1                   synchronous, active-low reset
//   load_valid in   1                   load_lit valid this cycle
//   load_lit   in   4                   signed literal; 0 = empty slot (false)
//   clear      in   1                   discard clause list, go to IDLE
//   start      in   1                   begin/restart search (pulse)
//   lit0..lit2 out  4 each              literals of current clause, to mux lit inputs
//   lit_true   in   3                   mux outputs, bit k = truth of litk under x_out
//   x_out      out  NUM_VARS            current assignment, to mux x inputs; on SAT, the solution
//   busy       out  1                   high in SEARCH
//   done       out  1                   high in SAT or UNSAT
//   sat        out  1                   high in SAT only
//   load_full  out  1                   all 2**LOG2_NUM_CLAUSES clauses filled
// BEHAVIOUR
//   Reset (rst_n=0 at edge): state IDLE, clause count 0, slot ptr 0, x_out 0, busy/done/sat/load_full 0, store cleared to 0.
//   States: IDLE, SEARCH, SAT, UNSAT. Loading is accepted in IDLE, SAT and UNSAT; ignored in SEARCH.
//   Load: each load_valid writes load_lit to slot (clause n_cl, position p), p = 0,1,2. p==2 completes clause, n_cl++.
//     Partially filled clause at start keeps remaining slots 0 and counts as a clause (start rounds n_cl up).
//     At n_cl == 2**LOG2_NUM_CLAUSES: load_full=1, further literals dropped, no wrap.
//   clear (any state, priority over start/load): n_cl=0, p=0, store zeroed, x_out=0, -> IDLE.
//   start in IDLE/SAT/UNSAT: ci=0, x_out=0, -> SEARCH next cycle. start during SEARCH ignored.
//   SEARCH, one clause per cycle: lit0..2 = store[ci] combinationally; clause_ok = |lit_true.
//     clause_ok & ci==n_cl-1 -> SAT, x_out held.      clause_ok & ci<n_cl-1 -> ci++.
//     !clause_ok & x_out==all-ones -> UNSAT.         !clause_ok otherwise -> x_out++, ci=0.
//   n_cl==0 at start: SEARCH lasts one cycle -> SAT, x_out=0.
//   Literal codes +-7, -8 are not valid loads; muxes treat them as true; the controller does not check them.
//   lit0..2 drive 0 outside SEARCH. Reset mid-search aborts immediately; the clause list is lost.
//   Worst case: 2**NUM_VARS * n_cl search cycles (2048 at defaults).
// CONFIGURATION
//   SAT_RESUME_EN defined: start in SAT resumes at x_out+1, ci=0 (enumerates all solutions). If x_out was all-ones,
//     -> UNSAT next cycle. start in IDLE/UNSAT still restarts at 0.
//   SAT_RESUME_EN undefined: start in SAT restarts at x_out=0; solutions repeat.
// TESTING   (bench instantiates three muxes on lit0..2/x_out)
//   Load {1,0,0},{-2,0,0}; start -> SAT after 3 SEARCH cycles, x_out=6'd1, sat=1, done=1.
//   Load {1,0,0},{-1,0,0}; start -> UNSAT after 96 SEARCH cycles, done=1, sat=0, x_out=6'd63.
//   Load {1,0,0}; start -> SAT x_out=1; start again -> SAT_RESUME_EN: x_out=3; without: x_out=1.
//   Load 97 literals -> load_full=1 after the 96th; the 97th is ignored; n_cl=32.
//   No loads; start -> SAT next cycle with x_out=0. Load 4 literals (1,2,3,-4); start -> 2 clauses.
//   rst_n low mid-SEARCH for one cycle -> all outputs reset values; start then yields SAT x_out=0 (empty list).

Source files
------------

// File: rtl/sat_search_ctrl.sv
// rtl/sat_search_ctrl.sv - brute-force CNF search sequencer driving three literal-select muxes.
// Optional build macro: SAT_RESUME_EN (start in SAT resumes enumeration at the next assignment).
module sat_search_ctrl #(
   parameter int NUM_VARS         = 6,
   parameter int LOG2_NUM_CLAUSES = 5
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load_valid,
   input  logic [3:0]          load_lit,
   input  logic                clear,
   input  logic                start,
   output logic [3:0]          lit0,
   output logic [3:0]          lit1,
   output logic [3:0]          lit2,
   input  logic [2:0]          lit_true,
   output logic [NUM_VARS-1:0] x_out,
   output logic                busy,
   output logic                done,
   output logic                sat,
   output logic                load_full
);

   localparam int NCL = 2 ** LOG2_NUM_CLAUSES;
   localparam int CW  = LOG2_NUM_CLAUSES + 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_SAT    = 2'd2,
      ST_UNSAT  = 2'd3
   } state_t;

   state_t                      state_q, state_d;
   logic [3:0]                  store_q [NCL][3];
   logic [3:0]                  store_d [NCL][3];
   logic [CW-1:0]               n_cl_q, n_cl_d;
   logic [1:0]                  pos_q, pos_d;
   logic [LOG2_NUM_CLAUSES-1:0] ci_q, ci_d;
   logic [NUM_VARS-1:0]         x_q, x_d;
   logic                        busy_q, busy_d;
   logic                        done_q, done_d;
   logic                        sat_q, sat_d;
   logic                        full_q, full_d;
   logic                        clause_ok;
   logic                        last_clause;

   assign clause_ok   = |lit_true;
   assign last_clause = ({1'b0, ci_q} == (n_cl_q - CW'(1)));

   always_comb begin
      state_d = state_q;
      store_d = store_q;
      n_cl_d  = n_cl_q;
      pos_d   = pos_q;
      ci_d    = ci_q;
      x_d     = x_q;

      if (clear) begin
         for (int i = 0; i < NCL; i++) begin
            for (int k = 0; k < 3; k++) begin
               store_d[i][k] = 4'd0;
            end
         end
         n_cl_d  = '0;
         pos_d   = 2'd0;
         ci_d    = '0;
         x_d     = '0;
         state_d = ST_IDLE;
      end else if (state_q == ST_SEARCH) begin
         // An empty list is trivially satisfied by the current assignment.
         if (n_cl_q == '0) begin
            state_d = ST_SAT;
         end else if (clause_ok) begin
            if (last_clause) state_d = ST_SAT;
            else             ci_d    = ci_q + 1'b1;
         end else if (&x_q) begin
            state_d = ST_UNSAT;
         end else begin
            x_d  = x_q + 1'b1;
            ci_d = '0;
         end
      end else if (start) begin
         // A partially filled clause still counts; its unused slots stay 0 (false).
         if (pos_q != 2'd0) begin
            n_cl_d = n_cl_q + 1'b1;
            pos_d  = 2'd0;
         end
         ci_d    = '0;
         x_d     = '0;
         state_d = ST_SEARCH;
`ifdef SAT_RESUME_EN
         if (state_q == ST_SAT) begin
            if (&x_q) begin
               x_d     = x_q;
               state_d = ST_UNSAT;
            end else begin
               x_d = x_q + 1'b1;
            end
         end
`endif
      end else if (load_valid && (n_cl_q != CW'(NCL))) begin
         store_d[n_cl_q[LOG2_NUM_CLAUSES-1:0]][pos_q] = load_lit;
         if (pos_q == 2'd2) begin
            pos_d  = 2'd0;
            n_cl_d = n_cl_q + 1'b1;
         end else begin
            pos_d = pos_q + 1'b1;
         end
      end

      busy_d = (state_d == ST_SEARCH);
      done_d = (state_d == ST_SAT) || (state_d == ST_UNSAT);
      sat_d  = (state_d == ST_SAT);
      full_d = (n_cl_d == CW'(NCL));
   end

   always_comb begin
      lit0 = 4'd0;
      lit1 = 4'd0;
      lit2 = 4'd0;
      if (state_q == ST_SEARCH) begin
         lit0 = store_q[ci_q][0];
         lit1 = store_q[ci_q][1];
         lit2 = store_q[ci_q][2];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         for (int i = 0; i < NCL; i++) begin
            for (int k = 0; k < 3; k++) begin
               store_q[i][k] <= 4'd0;
            end
         end
         n_cl_q <= '0;
         pos_q  <= 2'd0;
         ci_q   <= '0;
         x_q    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         sat_q  <= 1'b0;
         full_q <= 1'b0;
      end else begin
         state_q <= state_d;
         store_q <= store_d;
         n_cl_q  <= n_cl_d;
         pos_q   <= pos_d;
         ci_q    <= ci_d;
         x_q     <= x_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sat_q   <= sat_d;
         full_q  <= full_d;
      end
   end

   assign x_out     = x_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign sat       = sat_q;
   assign load_full = full_q;

endmodule

// File: tb/tb_sat_search_ctrl.sv
// tb/tb_sat_search_ctrl.sv - directed self-checking bench for sat_search_ctrl with modelled literal muxes.
module tb_sat_search_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       load_valid = 1'b0;
   logic [3:0] load_lit = 4'd0;
   logic       clear = 1'b0;
   logic       start = 1'b0;
   logic [3:0] lit0, lit1, lit2;
   logic [2:0] lit_true;
   logic [5:0] x_out;
   logic       busy, done, sat, load_full;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc;

   sat_search_ctrl #(.NUM_VARS(6), .LOG2_NUM_CLAUSES(5)) dut (
      .clk(clk), .rst_n(rst_n), .load_valid(load_valid), .load_lit(load_lit),
      .clear(clear), .start(start), .lit0(lit0), .lit1(lit1), .lit2(lit2),
      .lit_true(lit_true), .x_out(x_out), .busy(busy), .done(done), .sat(sat),
      .load_full(load_full)
   );

   always #5 clk = ~clk;

   function automatic logic mux_eval(input logic [3:0] lit, input logic [5:0] x);
      int v;
      v = $signed(lit);
      if (v == 0) return 1'b0;
      if (v > 0 && v <= 6) return x[v-1];
      if (v < 0 && -v <= 6) return ~x[-v-1];
      return 1'b1;
   endfunction

   always_comb lit_true = {mux_eval(lit2, x_out), mux_eval(lit1, x_out), mux_eval(lit0, x_out)};

   task automatic do_load(input logic [3:0] v);
      load_valid = 1'b1;
      load_lit   = v;
      @(negedge clk);
      load_valid = 1'b0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   task automatic run_search(output int cycles);
      cycles = 0;
      while (!done && cycles < 5000) begin
         cycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if ({busy, done, sat, load_full, x_out, lit0, lit1, lit2} !== 22'd0)
         $display("FAIL reset outputs got %h want 0", {busy, done, sat, load_full, x_out, lit0, lit1, lit2});
      else n_pass++;
   endtask

   task automatic test_sat_basic();
      do_clear();
      do_load(4'd1); do_load(4'd0); do_load(4'd0);
      do_load(4'hE); do_load(4'd0); do_load(4'd0);
      do_start();
      n_checks++;
      if (busy !== 1'b1 || lit0 !== 4'd1) $display("FAIL basic_search_entry busy=%b lit0=%h want 1/1", busy, lit0);
      else n_pass++;
      run_search(cyc);
      n_checks++;
      if (cyc !== 3) $display("FAIL basic_cycles got %0d want 3", cyc); else n_pass++;
      n_checks++;
      if ({done, sat, busy, x_out} !== {3'b110, 6'd1})
         $display("FAIL basic_result done/sat/busy/x got %b%b%b/%0d want 110/1", done, sat, busy, x_out);
      else n_pass++;
      n_checks++;
      if ({lit0, lit1, lit2} !== 12'd0) $display("FAIL basic_lits_idle got %h want 0", {lit0, lit1, lit2});
      else n_pass++;
   endtask

   task automatic test_unsat();
      do_clear();
      do_load(4'd1); do_load(4'd0); do_load(4'd0);
      do_load(4'hF); do_load(4'd0); do_load(4'd0);
      do_start();
      run_search(cyc);
      n_checks++;
      if (cyc !== 96) $display("FAIL unsat_cycles got %0d want 96", cyc); else n_pass++;
      n_checks++;
      if ({done, sat, x_out} !== {2'b10, 6'd63})
         $display("FAIL unsat_result done/sat/x got %b%b/%0d want 10/63", done, sat, x_out);
      else n_pass++;
   endtask

   task automatic test_resume();
      do_clear();
      do_load(4'd1);
      do_start();
      run_search(cyc);
      n_checks++;
      if ({sat, x_out} !== {1'b1, 6'd1}) $display("FAIL resume_first sat/x got %b/%0d want 1/1", sat, x_out);
      else n_pass++;
      do_start();
      run_search(cyc);
      n_checks++;
`ifdef SAT_RESUME_EN
      if ({sat, x_out} !== {1'b1, 6'd3}) $display("FAIL resume_second sat/x got %b/%0d want 1/3", sat, x_out);
      else n_pass++;
`else
      if ({sat, x_out} !== {1'b1, 6'd1}) $display("FAIL resume_second sat/x got %b/%0d want 1/1", sat, x_out);
      else n_pass++;
`endif
   endtask

   task automatic test_load_full();
      do_clear();
      for (int i = 0; i < 95; i++) do_load((i % 3 == 0) ? 4'd1 : 4'd0);
      n_checks++;
      if (load_full !== 1'b0) $display("FAIL full_before got %b want 0", load_full); else n_pass++;
      do_load(4'd0);
      n_checks++;
      if (load_full !== 1'b1) $display("FAIL full_after96 got %b want 1", load_full); else n_pass++;
      do_load(4'hF);
      do_start();
      run_search(cyc);
      n_checks++;
      if (cyc !== 33 || sat !== 1'b1 || x_out !== 6'd1)
         $display("FAIL full_search cycles/sat/x got %0d/%b/%0d want 33/1/1", cyc, sat, x_out);
      else n_pass++;
   endtask

   task automatic test_empty_and_round_up();
      do_clear();
      do_start();
      run_search(cyc);
      n_checks++;
      if (cyc !== 1 || sat !== 1'b1 || x_out !== 6'd0)
         $display("FAIL empty cycles/sat/x got %0d/%b/%0d want 1/1/0", cyc, sat, x_out);
      else n_pass++;
      do_clear();
      do_load(4'd1); do_load(4'd2); do_load(4'd3); do_load(4'hC);
      do_start();
      run_search(cyc);
      n_checks++;
      if (cyc !== 3 || sat !== 1'b1 || x_out !== 6'd1)
         $display("FAIL round_up cycles/sat/x got %0d/%b/%0d want 3/1/1", cyc, sat, x_out);
      else n_pass++;
   endtask

   task automatic test_reset_mid_search();
      do_clear();
      do_load(4'd1); do_load(4'd0); do_load(4'd0);
      do_load(4'hF); do_load(4'd0); do_load(4'd0);
      do_start();
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      n_checks++;
      if ({busy, done, sat, load_full, x_out, lit0, lit1, lit2} !== 22'd0)
         $display("FAIL midreset outputs got %h want 0", {busy, done, sat, load_full, x_out, lit0, lit1, lit2});
      else n_pass++;
      do_start();
      run_search(cyc);
      n_checks++;
      if (cyc !== 1 || sat !== 1'b1 || x_out !== 6'd0)
         $display("FAIL midreset_restart cycles/sat/x got %0d/%b/%0d want 1/1/0", cyc, sat, x_out);
      else n_pass++;
   endtask

   task automatic test_clear();
      do_clear();
      do_load(4'd3);
      do_start();
      run_search(cyc);
      n_checks++;
      if ({sat, x_out} !== {1'b1, 6'd4}) $display("FAIL clear_pre sat/x got %b/%0d want 1/4", sat, x_out);
      else n_pass++;
      clear = 1'b1;
      start = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      start = 1'b0;
      n_checks++;
      if ({busy, done, sat, x_out} !== 9'd0)
         $display("FAIL clear_prio busy/done/sat/x got %b%b%b/%0d want 000/0", busy, done, sat, x_out);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_sat_basic();
      test_unsat();
      test_resume();
      test_load_full();
      test_empty_and_round_up();
      test_reset_mid_search();
      test_clear();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
